training_sample_sequencer: RTL and testbench
============================================

TRAINING_SAMPLE_SEQUENCER -- requirements
Module: training_sample_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, max training samples stored.
REQ-002 SHALL have parameter HOLD, default 6, clock cycles each sample is presented to neural_network.
REQ-003 SHALL have parameter EPOCH_W, default 20, width of epoch counters.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port set_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port wr_en  input  1  sample-memory write strobe.
REQ-007 SHALL have port wr_addr  input  clog2(DEPTH)  sample index written.
REQ-008 SHALL have port wr_field  input  2  field written: 0=x1, 1=x2, 2=x3, 3=target.
REQ-009 SHALL have port wr_data  input  32  IEEE-754 single value written.
REQ-010 SHALL have port num_samples  input  clog2(DEPTH)+1  active samples, 1..DEPTH.
REQ-011 SHALL have port epochs  input  EPOCH_W  epochs to run.
REQ-012 SHALL have port start  input  1  begin run; level sampled each cycle.
REQ-013 SHALL have port stop  input  1  abort run.
REQ-014 SHALL have ports x1, x2, x3, target_out  output  32 each  sample driven to neural_network.
REQ-015 SHALL have port sample_new  output  1  one-cycle strobe on first cycle of each presented sample.
REQ-016 SHALL have port sample_idx  output  clog2(DEPTH)  index currently presented.
REQ-017 SHALL have port epoch_cnt  output  EPOCH_W  completed epochs.
REQ-018 SHALL have ports busy, done  output  1 each  run active / run finished.

Function
REQ-019 SHALL implement states IDLE, PRESENT, DONE; all outputs registered.
REQ-020 SHALL write wr_data into field wr_field of entry wr_addr on a clk edge with wr_en=1 only in IDLE or DONE; writes in PRESENT ignored; wr_addr>=DEPTH ignored.
REQ-021 IDLE/DONE with start=1, num_samples in 1..DEPTH and epochs>0: next cycle PRESENT, sample_idx=0, epoch_cnt=0, hold counter=0, sample_new=1, outputs = entry 0.
REQ-022 start with num_samples=0, num_samples>DEPTH or epochs=0: go to DONE, epoch_cnt=0, no PRESENT cycle.
REQ-023 In PRESENT each sample held exactly HOLD cycles; x1..target_out stable throughout.
REQ-024 After HOLD cycles: sample_idx+1 if < num_samples-1, else wrap to 0 and epoch_cnt+1.
REQ-025 When last sample of epoch epochs-1 ends: DONE, epoch_cnt=epochs, sample_idx holds last index.
REQ-026 Total PRESENT cycles = HOLD*num_samples*epochs; sample_new pulses num_samples*epochs times.
REQ-027 stop=1 in PRESENT: next cycle IDLE, counters held at current values; stop has priority over start; stop ignored in IDLE/DONE.
REQ-028 start in PRESENT ignored; start in DONE restarts per REQ-021.
REQ-029 x1..target_out SHALL be 0 in IDLE and DONE.
REQ-030 busy=1 only in PRESENT; done=1 only in DONE.
REQ-031 num_samples/epochs SHALL be captured at start; changes mid-run have no effect.

Reset
REQ-032 set_n=0 SHALL immediately force IDLE, all outputs 0, counters 0, regardless of clk, including mid-run.
REQ-033 Sample memory contents SHALL be unaffected by reset.
REQ-034 First start honoured on first rising edge after set_n rises.

Verification
REQ-035 Load entries 0..2: x=3F800000/target 3F400000, x=40400000/3F000000, x=40C00000/3EC00000; num_samples=3, epochs=2, start -> 36 PRESENT cycles, order 0,1,2,0,1,2, 6 cycles each, 6 sample_new pulses, DONE with epoch_cnt=2.
REQ-036 epochs=0, start -> DONE next cycle, busy never 1, outputs 0.
REQ-037 Run epochs=5, stop at cycle 20 -> IDLE next cycle, epoch_cnt=1, sample_idx=0, outputs 0.
REQ-038 wr_en during PRESENT to entry 1 with 0x41000000 -> next epoch still presents 40400000.
REQ-039 set_n=0 asynchronously mid-sample -> outputs 0 same instant; after release, start replays unchanged memory.
REQ-040 start held high continuously in DONE -> immediate restart, epoch_cnt reset to 0.

Source files
------------

// File: rtl/training_sample_sequencer.sv
// Presents stored training samples (x1, x2, x3, target) to a neural network,
// holding each for HOLD cycles and looping over the sample set for a given number of epochs.
module training_sample_sequencer #(
  parameter int DEPTH   = 4,
  parameter int HOLD    = 6,
  parameter int EPOCH_W = 20
) (
  input  logic                                     clk,
  input  logic                                     set_n,
  input  logic                                     wr_en,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] wr_addr,
  input  logic [1:0]                               wr_field,
  input  logic [31:0]                              wr_data,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1):0]   num_samples,
  input  logic [EPOCH_W-1:0]                       epochs,
  input  logic                                     start,
  input  logic                                     stop,
  output logic [31:0]                              x1,
  output logic [31:0]                              x2,
  output logic [31:0]                              x3,
  output logic [31:0]                              target_out,
  output logic                                     sample_new,
  output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] sample_idx,
  output logic [EPOCH_W-1:0]                       epoch_cnt,
  output logic                                     busy,
  output logic                                     done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [AW:0]   DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic [1:0] {IDLE, PRESENT, DONE} state_t;

  state_t             state, state_nxt;
  logic [31:0]        mem_x1 [DEPTH];
  logic [31:0]        mem_x2 [DEPTH];
  logic [31:0]        mem_x3 [DEPTH];
  logic [31:0]        mem_t  [DEPTH];

  logic [HW-1:0]      hold_cnt, hold_nxt;
  logic [AW:0]        num_q, num_nxt;
  logic [EPOCH_W-1:0] epochs_q, epochs_nxt;
  logic [AW-1:0]      idx_nxt;
  logic [EPOCH_W-1:0] ep_nxt;
  logic               new_nxt, load;
  logic [31:0]        x1_nxt, x2_nxt, x3_nxt, t_nxt;
  logic               run_ok;

  // Sample memory has no reset so its contents survive set_n.
  always_ff @(posedge clk) begin
    if (wr_en && state != PRESENT && ({1'b0, wr_addr} < DEPTH_V)) begin
      case (wr_field)
        2'd0:    mem_x1[wr_addr] <= wr_data;
        2'd1:    mem_x2[wr_addr] <= wr_data;
        2'd2:    mem_x3[wr_addr] <= wr_data;
        default: mem_t[wr_addr]  <= wr_data;
      endcase
    end
  end

  assign run_ok = (num_samples != '0) && (num_samples <= DEPTH_V) && (epochs != '0);

  always_comb begin
    state_nxt  = state;
    idx_nxt    = sample_idx;
    ep_nxt     = epoch_cnt;
    hold_nxt   = hold_cnt;
    num_nxt    = num_q;
    epochs_nxt = epochs_q;
    new_nxt    = 1'b0;
    load       = 1'b0;
    x1_nxt     = x1;
    x2_nxt     = x2;
    x3_nxt     = x3;
    t_nxt      = target_out;
    case (state)
      PRESENT: begin
        if (stop) begin
          state_nxt = IDLE;
          x1_nxt = '0; x2_nxt = '0; x3_nxt = '0; t_nxt = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          hold_nxt = '0;
          if ({1'b0, sample_idx} == num_q - (AW+1)'(1)) begin
            if (epoch_cnt == epochs_q - EPOCH_W'(1)) begin
              state_nxt = DONE;
              ep_nxt    = epochs_q;
              x1_nxt = '0; x2_nxt = '0; x3_nxt = '0; t_nxt = '0;
            end else begin
              idx_nxt = '0;
              ep_nxt  = epoch_cnt + EPOCH_W'(1);
              new_nxt = 1'b1;
              load    = 1'b1;
            end
          end else begin
            idx_nxt = sample_idx + AW'(1);
            new_nxt = 1'b1;
            load    = 1'b1;
          end
        end else begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      default: begin
        if (start) begin
          idx_nxt  = '0;
          ep_nxt   = '0;
          hold_nxt = '0;
          if (run_ok) begin
            state_nxt  = PRESENT;
            num_nxt    = num_samples;
            epochs_nxt = epochs;
            new_nxt    = 1'b1;
            load       = 1'b1;
          end else begin
            state_nxt = DONE;
          end
        end
      end
    endcase
    if (load) begin
      x1_nxt = mem_x1[idx_nxt];
      x2_nxt = mem_x2[idx_nxt];
      x3_nxt = mem_x3[idx_nxt];
      t_nxt  = mem_t[idx_nxt];
    end
  end

  always_ff @(posedge clk or negedge set_n) begin
    if (!set_n) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      num_q      <= '0;
      epochs_q   <= '0;
      sample_idx <= '0;
      epoch_cnt  <= '0;
      sample_new <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      x1         <= '0;
      x2         <= '0;
      x3         <= '0;
      target_out <= '0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_nxt;
      num_q      <= num_nxt;
      epochs_q   <= epochs_nxt;
      sample_idx <= idx_nxt;
      epoch_cnt  <= ep_nxt;
      sample_new <= new_nxt;
      busy       <= (state_nxt == PRESENT);
      done       <= (state_nxt == DONE);
      x1         <= x1_nxt;
      x2         <= x2_nxt;
      x3         <= x3_nxt;
      target_out <= t_nxt;
    end
  end

endmodule

// File: tb/tb_training_sample_sequencer.sv
// Directed self-checking bench for training_sample_sequencer with default parameters.
module tb_training_sample_sequencer;

  logic        clk = 1'b0;
  logic        set_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [1:0]  wr_field = '0;
  logic [31:0] wr_data = '0;
  logic [2:0]  num_samples = '0;
  logic [19:0] epochs = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] x1, x2, x3, target_out;
  logic        sample_new;
  logic [1:0]  sample_idx;
  logic [19:0] epoch_cnt;
  logic        busy, done;

  int errors = 0;
  int checks = 0;

  training_sample_sequencer #(.DEPTH(4), .HOLD(6), .EPOCH_W(20)) dut (
    .clk(clk), .set_n(set_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_field(wr_field),
    .wr_data(wr_data), .num_samples(num_samples), .epochs(epochs), .start(start),
    .stop(stop), .x1(x1), .x2(x2), .x3(x3), .target_out(target_out),
    .sample_new(sample_new), .sample_idx(sample_idx), .epoch_cnt(epoch_cnt),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_x(input int i);
    case (i)
      0: return 32'h3F800000;
      1: return 32'h40400000;
      2: return 32'h40C00000;
      default: return 32'h41200000;
    endcase
  endfunction

  function automatic logic [31:0] exp_t(input int i);
    case (i)
      0: return 32'h3F400000;
      1: return 32'h3F000000;
      2: return 32'h3EC00000;
      default: return 32'h3E800000;
    endcase
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic write_mem(input int a, input int f, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = 2'(a); wr_field = 2'(f); wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(input int n, input int e);
    num_samples = 3'(n); epochs = 20'(e); start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({x1, x2, x3, target_out} !== '0 || {busy, done, sample_new} !== 3'b000
        || sample_idx !== 2'd0 || epoch_cnt !== 20'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b new=%b idx=%0d ep=%0d x1=%h, required all zero",
               busy, done, sample_new, sample_idx, epoch_cnt, x1);
    end
    step(); step();
    set_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      write_mem(i, 0, exp_x(i));
      write_mem(i, 1, exp_x(i));
      write_mem(i, 2, exp_x(i));
      write_mem(i, 3, exp_t(i));
    end
  endtask

  task automatic test_two_epochs;
    int pulses = 0;
    pulse_start(3, 2);
    num_samples = 3'd1; epochs = 20'd1;  // mid-run changes must be ignored
    for (int c = 0; c < 36; c++) begin
      int i = (c / 6) % 3;
      logic nw = (c % 6 == 0);
      if (sample_new === 1'b1) pulses++;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || sample_idx !== 2'(i) || epoch_cnt !== 20'(c / 18)
          || sample_new !== nw) begin
        errors++;
        $display("FAIL run_ctrl c=%0d: busy=%b done=%b idx=%0d ep=%0d new=%b, required 1 0 %0d %0d %b",
                 c, busy, done, sample_idx, epoch_cnt, sample_new, i, c / 18, nw);
      end
      checks++;
      if (x1 !== exp_x(i) || x2 !== exp_x(i) || x3 !== exp_x(i) || target_out !== exp_t(i)) begin
        errors++;
        $display("FAIL run_data c=%0d: x1=%h x2=%h x3=%h t=%h, required %h/%h", c, x1, x2, x3,
                 target_out, exp_x(i), exp_t(i));
      end
      step();
    end
    checks++;
    if (pulses != 6) begin
      errors++;
      $display("FAIL sample_new_count: got %0d, required 6", pulses);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || epoch_cnt !== 20'd2 || sample_idx !== 2'd2
        || {x1, x2, x3, target_out} !== '0) begin
      errors++;
      $display("FAIL run_done: done=%b busy=%b ep=%0d idx=%0d x1=%h, required 1 0 2 2 0",
               done, busy, epoch_cnt, sample_idx, x1);
    end
  endtask

  task automatic test_zero_epochs;
    pulse_start(3, 0);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || epoch_cnt !== 20'd0 || {x1, target_out} !== '0) begin
        errors++;
        $display("FAIL zero_epochs c=%0d: done=%b busy=%b ep=%0d x1=%h, required 1 0 0 0",
                 c, done, busy, epoch_cnt, x1);
      end
      stop = (c == 1);  // stop in DONE has no effect
      step();
    end
    stop = 1'b0;
  endtask

  task automatic test_invalid_num;
    pulse_start(0, 2);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL num_zero: done=%b busy=%b, required 1 0", done, busy);
    end
    pulse_start(5, 2);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL num_over_depth: done=%b busy=%b, required 1 0", done, busy);
    end
  endtask

  task automatic test_full_depth;
    pulse_start(4, 1);
    repeat (18) step();
    checks++;
    if (sample_idx !== 2'd3 || x1 !== exp_x(3) || target_out !== exp_t(3) || sample_new !== 1'b1) begin
      errors++;
      $display("FAIL full_depth_last: idx=%0d x1=%h t=%h new=%b, required 3 %h %h 1",
               sample_idx, x1, target_out, sample_new, exp_x(3), exp_t(3));
    end
    repeat (6) step();
    checks++;
    if (done !== 1'b1 || epoch_cnt !== 20'd1 || sample_idx !== 2'd3) begin
      errors++;
      $display("FAIL full_depth_done: done=%b ep=%0d idx=%0d, required 1 1 3", done, epoch_cnt, sample_idx);
    end
  endtask

  task automatic test_stop;
    pulse_start(3, 5);
    repeat (19) step();
    checks++;
    if (busy !== 1'b1 || sample_idx !== 2'd0 || epoch_cnt !== 20'd1) begin
      errors++;
      $display("FAIL stop_pre: busy=%b idx=%0d ep=%0d, required 1 0 1", busy, sample_idx, epoch_cnt);
    end
    stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || epoch_cnt !== 20'd1 || sample_idx !== 2'd0
        || sample_new !== 1'b0 || {x1, x2, x3, target_out} !== '0) begin
      errors++;
      $display("FAIL stop_idle: busy=%b done=%b ep=%0d idx=%0d new=%b x1=%h, required 0 0 1 0 0 0",
               busy, done, epoch_cnt, sample_idx, sample_new, x1);
    end
  endtask

  task automatic test_write_in_present;
    bit seen = 0;
    pulse_start(3, 2);
    repeat (3) step();
    write_mem(1, 0, 32'h41000000);
    repeat (20) step();
    checks++;
    if (sample_idx !== 2'd1 || epoch_cnt !== 20'd1 || x1 !== 32'h40400000) begin
      errors++;
      $display("FAIL write_ignored: idx=%0d ep=%0d x1=%h, required 1 1 40400000",
               sample_idx, epoch_cnt, x1);
    end
    for (int c = 0; c < 40 && !seen; c++) begin
      if (done === 1'b1) seen = 1;
      else step();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL write_run_timeout: done=%b, required 1 within 40 cycles", done);
    end
  endtask

  task automatic test_async_reset;
    pulse_start(3, 2);
    repeat (8) step();
    checks++;
    if (x1 !== 32'h40400000 || sample_idx !== 2'd1) begin
      errors++;
      $display("FAIL areset_pre: x1=%h idx=%0d, required 40400000 1", x1, sample_idx);
    end
    #3 set_n = 1'b0;
    #1;
    checks++;
    if ({x1, x2, x3, target_out} !== '0 || {busy, done, sample_new} !== 3'b000
        || sample_idx !== 2'd0 || epoch_cnt !== 20'd0) begin
      errors++;
      $display("FAIL areset_instant: x1=%h busy=%b idx=%0d ep=%0d, required all zero",
               x1, busy, sample_idx, epoch_cnt);
    end
    @(posedge clk);
    #2 set_n = 1'b1;
    pulse_start(3, 2);
    checks++;
    if (busy !== 1'b1 || sample_new !== 1'b1 || sample_idx !== 2'd0 || x1 !== exp_x(0)
        || target_out !== exp_t(0)) begin
      errors++;
      $display("FAIL areset_restart: busy=%b new=%b idx=%0d x1=%h t=%h, required 1 1 0 %h %h",
               busy, sample_new, sample_idx, x1, target_out, exp_x(0), exp_t(0));
    end
    repeat (6) step();
    checks++;
    if (x1 !== 32'h40400000 || x3 !== 32'h40400000 || target_out !== 32'h3F000000) begin
      errors++;
      $display("FAIL areset_mem_kept: x1=%h x3=%h t=%h, required 40400000 40400000 3F000000",
               x1, x3, target_out);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_restart_held;
    num_samples = 3'd1; epochs = 20'd1; start = 1'b1;
    step();
    repeat (5) step();
    checks++;
    if (busy !== 1'b1 || epoch_cnt !== 20'd0) begin
      errors++;
      $display("FAIL held_present: busy=%b ep=%0d, required 1 0", busy, epoch_cnt);
    end
    step();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || epoch_cnt !== 20'd1) begin
      errors++;
      $display("FAIL held_done: done=%b busy=%b ep=%0d, required 1 0 1", done, busy, epoch_cnt);
    end
    step();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || sample_new !== 1'b1 || epoch_cnt !== 20'd0
        || x1 !== exp_x(0)) begin
      errors++;
      $display("FAIL held_restart: busy=%b done=%b new=%b ep=%0d x1=%h, required 1 0 1 0 %h",
               busy, done, sample_new, epoch_cnt, x1, exp_x(0));
    end
    start = 1'b0; stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_two_epochs();
    test_zero_epochs();
    test_invalid_num();
    test_full_depth();
    test_stop();
    test_write_in_present();
    test_async_reset();
    test_restart_held();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
